// File: rtl/stopwatch_ctrl.sv
// Mode controller for an MM:SS stopwatch: button synchronisers, STOP/RUN/SET
// state machine, 1 Hz prescaler, set-mode increments, blink and carry gating.
module stopwatch_ctrl #(
  parameter int DIV  = 50000000,
  parameter int DIVW = 26
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_SS,
  input  logic BTN_CLR,
  input  logic BTN_MODE,
  input  logic BTN_UP,
  input  logic SEC_CA,
  output logic SEC_EN,
  output logic SEC_INC,
  output logic MIN_EN,
  output logic MIN_INC,
  output logic CNT_CLR,
  output logic RUNNING,
  output logic DISP_SEC,
  output logic DISP_MIN
);

  typedef enum logic [1:0] {IDLE, RUN, SET_SEC, SET_MIN} state_t;

  localparam int B_CLR  = 0;
  localparam int B_SS   = 1;
  localparam int B_MODE = 2;
  localparam int B_UP   = 3;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(DIV / 2);

  logic [3:0] btn_raw;
  logic [3:0] rise;
  logic [1:0] settle_reg;
  logic       settled;

  assign btn_raw = {BTN_UP, BTN_MODE, BTN_SS, BTN_CLR};
  assign settled = (settle_reg == 2'd3);

  // Edges are masked until the chain has refilled after reset, so a button
  // held through reset release is not mistaken for a fresh press.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      settle_reg <= 2'd0;
    end else if (!settled) begin
      settle_reg <= settle_reg + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic meta_reg;
      logic sync_reg;
      logic prev_reg;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          prev_reg <= 1'b0;
        end else begin
          meta_reg <= btn_raw[gi];
          sync_reg <= meta_reg;
          prev_reg <= sync_reg;
        end
      end

      assign rise[gi] = sync_reg & ~prev_reg & settled;
    end
  endgenerate

  logic win_clr, win_ss, win_mode, win_up;

  always_comb begin
    win_clr  = rise[B_CLR];
    win_ss   = rise[B_SS]   & ~rise[B_CLR];
    win_mode = rise[B_MODE] & ~rise[B_SS] & ~rise[B_CLR];
    win_up   = rise[B_UP]   & ~rise[B_MODE] & ~rise[B_SS] & ~rise[B_CLR];
  end

  state_t          state_reg, state_next;
  logic [DIVW-1:0] cnt_reg, cnt_next, cnt_adv;
  logic            wrap;
  logic            sec_en_reg, sec_en_next;
  logic            sec_inc_reg, sec_inc_next;
  logic            min_inc_reg, min_inc_next;
  logic            clr_reg, clr_next;
  logic            disp_sec_reg, disp_sec_next;
  logic            disp_min_reg, disp_min_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      sec_en_reg   <= 1'b0;
      sec_inc_reg  <= 1'b0;
      min_inc_reg  <= 1'b0;
      clr_reg      <= 1'b0;
      disp_sec_reg <= 1'b1;
      disp_min_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      sec_en_reg   <= sec_en_next;
      sec_inc_reg  <= sec_inc_next;
      min_inc_reg  <= min_inc_next;
      clr_reg      <= clr_next;
      disp_sec_reg <= disp_sec_next;
      disp_min_reg <= disp_min_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    sec_en_next  = 1'b0;
    sec_inc_next = 1'b0;
    min_inc_next = 1'b0;
    clr_next     = 1'b0;
    wrap         = (cnt_reg == DIV_LAST);
    cnt_adv      = wrap ? '0 : cnt_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (win_clr) begin
          clr_next = 1'b1;
          cnt_next = '0;
        end else if (win_ss) begin
          state_next = RUN;
        end else if (win_mode) begin
          state_next = SET_SEC;
          cnt_next   = '0;
        end
      end
      RUN: begin
        // Stopping freezes the fraction so a restart resumes from it.
        if (win_ss) begin
          state_next = IDLE;
        end else begin
          cnt_next    = cnt_adv;
          sec_en_next = wrap;
        end
      end
      SET_SEC: begin
        cnt_next = cnt_adv;
        if (win_clr) begin
          clr_next = 1'b1;
        end else if (win_mode) begin
          state_next = SET_MIN;
        end else if (win_up) begin
          sec_inc_next = 1'b1;
        end
      end
      SET_MIN: begin
        cnt_next = cnt_adv;
        if (win_clr) begin
          clr_next = 1'b1;
        end else if (win_mode) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (win_up) begin
          min_inc_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    disp_sec_next = (state_next == SET_SEC) ? (cnt_next < DIV_HALF) : 1'b1;
    disp_min_next = (state_next == SET_MIN) ? (cnt_next < DIV_HALF) : 1'b1;
  end

  assign SEC_EN   = sec_en_reg;
  assign SEC_INC  = sec_inc_reg;
  assign MIN_INC  = min_inc_reg;
  assign CNT_CLR  = clr_reg;
  assign RUNNING  = (state_reg == RUN);
  assign MIN_EN   = SEC_CA & RUNNING;
  assign DISP_SEC = disp_sec_reg;
  assign DISP_MIN = disp_min_reg;

endmodule
